// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and halt sequencing controller for the 5-stage pipeline.
// Define PERF_CNT_EN to build the saturating performance counters; otherwise they read 0.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_hault,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rW,
    input  logic             ex_rw_en,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rW,
    input  logic             mem_rw_en,
    input  logic [4:0]       wb_rW,
    input  logic             wb_rw_en,
    input  logic             wb_hault,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       load_use;

    assign load_use = ex_memread && ex_rw_en && (ex_rW != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rW)) || (id_use_rt && (id_rt == ex_rW)));

    // EX/MEM has the younger result, so it takes priority over MEM/WB.
    always_comb begin
        fwd_a = 2'd0;
        if (mem_rw_en && (mem_rW != 5'd0) && (mem_rW == ex_rs)) begin
            fwd_a = 2'd1;
        end else if (wb_rw_en && (wb_rW != 5'd0) && (wb_rW == ex_rs)) begin
            fwd_a = 2'd2;
        end
        fwd_b = 2'd0;
        if (mem_rw_en && (mem_rW != 5'd0) && (mem_rW == ex_rt)) begin
            fwd_b = 2'd1;
        end else if (wb_rw_en && (wb_rW != 5'd0) && (wb_rW == ex_rt)) begin
            fwd_b = 2'd2;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        case (state_q)
            RUN: begin
                // A redirect squashes the ID instruction, so its stall or halt is moot.
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_hault) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = DRAIN;
                end
                if (wb_hault) begin
                    state_d = HALT;
                end
            end
            DRAIN: begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                if (wb_hault) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                pipe_freeze = 1'b1;
                if (go) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == HALT);

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cycle_q, stall_q, flush_q;
    logic             run_ev, stall_ev, flush_ev;

    assign run_ev   = (state_q == RUN) || (state_q == DRAIN);
    assign flush_ev = (state_q == RUN) && ex_redirect;
    assign stall_ev = (state_q == RUN) && !ex_redirect && load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (run_ev && (cycle_q != CNT_MAX)) begin
                cycle_q <= cycle_q + CNT_ONE;
            end
            if (stall_ev && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (flush_ev && (flush_q != CNT_MAX)) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver queues per-cycle expectations, a
// negedge monitor pops and compares. Counter expectations collapse to 0 without PERF_CNT_EN.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, halted}
    localparam logic [5:0] RUN_IDLE = 6'b110000;
    localparam logic [5:0] STALL    = 6'b000100;
    localparam logic [5:0] REDIR    = 6'b111100;
    localparam logic [5:0] DRN      = 6'b011000;
    localparam logic [5:0] HALTV    = 6'b000011;

    logic clk = 1'b0;
    logic rst_n;
    logic go;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rW, mem_rW, wb_rW;
    logic id_use_rs, id_use_rt, id_hault, ex_rw_en, ex_memread, ex_redirect;
    logic mem_rw_en, wb_rw_en, wb_hault;
    logic pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;

    typedef struct {
        string             name;
        logic [9:0]        ctl;
        logic [3*CW-1:0]   cnt;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int errors = 0;
    int checks = 0;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_hault(id_hault),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rW(ex_rW), .ex_rw_en(ex_rw_en),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_rW(mem_rW), .mem_rw_en(mem_rw_en),
        .wb_rW(wb_rW), .wb_rw_en(wb_rw_en), .wb_hault(wb_hault),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pipe_freeze(pipe_freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst_n = 1'b1; go = 1'b0;
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_hault = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_rW = '0; ex_rw_en = 1'b0; ex_memread = 1'b0;
        ex_redirect = 1'b0;
        mem_rW = '0; mem_rw_en = 1'b0; wb_rW = '0; wb_rw_en = 1'b0; wb_hault = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input string nm, input logic [5:0] c, input logic [1:0] fa,
                        input logic [1:0] fb, input int cy, input int st, input int fl);
        exp_t e;
        logic [CW-1:0] a, b, d;
`ifdef PERF_CNT_EN
        a = cy[CW-1:0]; b = st[CW-1:0]; d = fl[CW-1:0];
`else
        a = '0; b = '0; d = '0;
`endif
        e.name = nm;
        e.ctl  = {c, fa, fb};
        e.cnt  = {a, b, d};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            checks++;
            if ({pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, halted, fwd_a, fwd_b}
                    !== m.ctl || {cycle_cnt, stall_cnt, flush_cnt} !== m.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%h, want ctl=%b cnt=%h", m.name,
                         {pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, halted,
                          fwd_a, fwd_b}, {cycle_cnt, stall_cnt, flush_cnt}, m.ctl, m.cnt);
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        push("reset", RUN_IDLE, 2'd0, 2'd0, 0, 0, 0);

        nxt(); mem_rw_en = 1; mem_rW = 5; wb_rw_en = 1; wb_rW = 5; ex_rs = 5; ex_rt = 5;
        push("fwd_exmem", RUN_IDLE, 2'd1, 2'd1, 0, 0, 0);
        nxt(); mem_rW = 5; wb_rw_en = 1; wb_rW = 5; ex_rs = 5; ex_rt = 5;
        push("fwd_memwb", RUN_IDLE, 2'd2, 2'd2, 1, 0, 0);
        nxt(); mem_rw_en = 1; wb_rw_en = 1;
        push("fwd_r0", RUN_IDLE, 2'd0, 2'd0, 2, 0, 0);
        nxt(); ex_rs = 9; ex_rt = 3; mem_rw_en = 1; mem_rW = 3; wb_rw_en = 1; wb_rW = 9;
        push("fwd_mixed", RUN_IDLE, 2'd2, 2'd1, 3, 0, 0);

        nxt(); ex_memread = 1; ex_rw_en = 1; ex_rW = 8; id_rt = 8; id_use_rt = 1;
        push("load_use", STALL, 2'd0, 2'd0, 4, 0, 0);
        nxt();
        push("after_stall", RUN_IDLE, 2'd0, 2'd0, 5, 1, 0);
        nxt(); ex_memread = 1; ex_rw_en = 1; ex_rW = 8; id_rt = 8;
        push("no_use_rt", RUN_IDLE, 2'd0, 2'd0, 6, 1, 0);
        nxt(); ex_memread = 1; ex_rw_en = 1; id_use_rs = 1;
        push("load_r0", RUN_IDLE, 2'd0, 2'd0, 7, 1, 0);

        nxt(); ex_redirect = 1; ex_memread = 1; ex_rw_en = 1; ex_rW = 8; id_rt = 8;
        id_use_rt = 1; id_hault = 1;
        push("redirect_lu", REDIR, 2'd0, 2'd0, 8, 1, 0);
        nxt();
        push("after_redir", RUN_IDLE, 2'd0, 2'd0, 9, 1, 1);

        nxt(); id_hault = 1;
        push("halt_in_id", DRN, 2'd0, 2'd0, 10, 1, 1);
        nxt(); go = 1;
        push("drain1_go", DRN, 2'd0, 2'd0, 11, 1, 1);
        nxt();
        push("drain2", DRN, 2'd0, 2'd0, 12, 1, 1);
        nxt(); wb_hault = 1;
        push("drain3_wb", DRN, 2'd0, 2'd0, 13, 1, 1);
        nxt();
        push("halt1", HALTV, 2'd0, 2'd0, 14, 1, 1);
        nxt(); ex_redirect = 1;
        push("halt_redir", HALTV, 2'd0, 2'd0, 14, 1, 1);
        nxt(); go = 1;
        push("halt_go", HALTV, 2'd0, 2'd0, 14, 1, 1);
        nxt();
        push("resume", RUN_IDLE, 2'd0, 2'd0, 14, 1, 1);
        nxt();
        push("run_a", RUN_IDLE, 2'd0, 2'd0, 15, 1, 1);
        nxt();
        push("run_sat", RUN_IDLE, 2'd0, 2'd0, 15, 1, 1);

        nxt(); id_hault = 1;
        push("halt2_id", DRN, 2'd0, 2'd0, 15, 1, 1);
        nxt();
        push("drain_b", DRN, 2'd0, 2'd0, 15, 1, 1);
        nxt(); rst_n = 1'b0;
        push("async_reset", RUN_IDLE, 2'd0, 2'd0, 0, 0, 0);
        nxt();
        push("post_reset", RUN_IDLE, 2'd0, 2'd0, 0, 0, 0);
        nxt(); wb_hault = 1;
        push("wb_hault_run", RUN_IDLE, 2'd0, 2'd0, 1, 0, 0);
        nxt(); go = 1;
        push("forced_halt", HALTV, 2'd0, 2'd0, 2, 0, 0);
        nxt();
        push("resume2", RUN_IDLE, 2'd0, 2'd0, 2, 0, 0);
        for (int i = 0; i < 20; i++) begin
            nxt();
            push("saturate", RUN_IDLE, 2'd0, 2'd0, (3 + i > 15) ? 15 : 3 + i, 0, 0);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
